imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes a byte stream into the CPU's 256 x 8 instruction memory, which the fetch stage reads. It accepts a framed download (length, payload, checksum) over a valid/ready byte interface and issues one memory write per payload byte. It holds the CPU in reset until a frame completes with a good checksum. It sits between the host/debug byte link and the instruction memory write port; `cpu_hold` is ORed into the CPU's `reset`.

## Interface
- `ADDR_W`, 8: instruction memory address width (depth 2^ADDR_W).
- `DATA_W`, 8: byte width of stream and memory word.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  stream byte valid.
- `s_data`  in  DATA_W  stream byte.
- `s_ready`  out  1  loader can accept a byte.
- `restart`  in  1  single-cycle request to begin a new download.
- `mem_we`  out  1  instruction memory write enable.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `cpu_hold`  out  1  keeps the CPU in reset while high.
- `done`  out  1  one-cycle pulse on successful load.
- `err`  out  1  sticky checksum-failure flag.

## Operation
- Frame format: LEN byte, then N payload bytes, then CHK byte.
  - LEN = 1..255 gives N = LEN; LEN = 0 gives N = 256.
  - The frame is good when (sum of payload + CHK) mod 256 == 0.
- States:
  - LEN: wait for the length byte. Latch the count, clear the sum and address, go to DATA.
  - DATA: each accepted byte adds to the 8-bit wrapping sum and issues a write. After the Nth byte, go to CHK.
  - CHK: compare the checksum byte. Good goes to RUN; bad goes to ERR.
  - RUN: load complete; CPU released.
  - ERR: load failed; CPU stays held.
- Handshake: a byte transfers on a rising edge with `s_valid && s_ready`. The source may drop `s_valid` between bytes with no effect.
- `s_ready` is 1 in LEN, DATA and CHK, and 0 in RUN and ERR. It is registered and decoded from state only.
- Write address runs 0..N-1. It is ADDR_W bits wide, so for N = 256 the last write is at 255 and the counter wraps to 0 with no extra write.
- `restart` forces LEN from any state on the next edge.
  - Sets `cpu_hold` = 1 and clears `err`.
  - Clears the address and sum.
  - Any byte handshaken in the same cycle is discarded and causes no write.
- The memory port has no backpressure; every write completes in its cycle.

## Timing
- Reset values:
  - state = LEN.
  - `s_ready` = 1 and `cpu_hold` = 1.
  - `mem_we`, `done` and `err` = 0.
  - `mem_addr` and `mem_wdata` = 0.
- Reset mid-frame abandons the frame. No write occurs after reset asserts. Memory contents are untouched.
- Write latency: a payload byte accepted at edge k produces `mem_we` = 1 with `mem_addr` and `mem_wdata` valid in the cycle following edge k (all registered). `mem_we` is 0 in every other cycle.
- CHK accepted at edge k:
  - Good checksum: state = RUN, `done` = 1 for exactly the cycle after edge k, and `cpu_hold` falls in that same cycle.
  - Bad checksum: state = ERR, `err` = 1 and `cpu_hold` stays 1, both from the cycle after edge k.
- Back-to-back bytes are accepted at one per cycle, so a full frame takes a minimum of N+2 cycles.
- `restart` at edge k: `cpu_hold` = 1 and `s_ready` = 1 from the cycle after edge k.
- `restart` in RUN re-holds the CPU mid-execution; this is intended.

## Structure
- Shared package `loader_pkg`:
  - State enum {LEN, DATA, CHK, RUN, ERR}.
  - `LEN_FULL` = 0 (the encoding for a 256-byte frame).
  - Checksum width constant.
- Single flat module; no sub-module. The checksum accumulator and byte counter are inline registers.
- The payload counter is ADDR_W+1 bits so that N = 256 is representable.

## Test plan
- Good load: stream 0x03, 0x12, 0x34, 0x56, 0x64 back-to-back.
  - Expect writes (0, 0x12), (1, 0x34), (2, 0x56).
  - Expect a single `done` pulse, `cpu_hold` 1 -> 0, and `err` = 0.
- Bad checksum: same frame with CHK = 0x65.
  - Expect the three writes, then `err` = 1, `cpu_hold` = 1, `s_ready` = 0, and no `done`.
  - Then pulse `restart` -> `err` = 0, `s_ready` = 1.
- Full frame: LEN = 0x00 plus 256 bytes of value i, with the matching CHK.
  - Expect 256 writes at addresses 0..255 and no write at address 0 after the wrap.
  - Expect `done` pulsed.
- Gapped stream: `s_valid` toggles 1/0 every cycle during the 0x03 frame.
  - Expect the same writes and data as the good load, with `mem_we` only after accepted bytes.
- Reset mid-load: assert `reset` after the second payload byte.
  - Expect all outputs at reset values and no further writes.
  - A fresh good frame must then load correctly starting at address 0.
- Restart collision: in DATA, assert `restart` in the same cycle as a handshaken byte 0xAA.
  - Expect no write of 0xAA and state LEN.
  - The next byte must be treated as LEN.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package loader_pkg;

    // Loader phases: length byte, payload bytes, checksum byte, then a terminal outcome
    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CHK  = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Length byte value that encodes a full 256-byte frame
    localparam int unsigned LEN_FULL = 0;

    // Width of the wrapping payload checksum accumulator
    localparam int unsigned CHK_W = 8;

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 256 x 8 instruction memory; holds the CPU
// in reset until a frame with a good checksum has been written.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [CHK_W-1:0]    sum, sum_n;
    logic [ADDR_W-1:0]   ptr, ptr_n;

    logic                ready_n;
    logic                we_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wdata_n;
    logic                hold_n;
    logic                done_n;
    logic                err_n;

    logic                hs;

    assign hs = s_valid && s_ready;

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_LEN;
            cnt       <= '0;
            sum       <= '0;
            ptr       <= '0;
            s_ready   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sum       <= sum_n;
            ptr       <= ptr_n;
            s_ready   <= ready_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            cpu_hold  <= hold_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    // Next-state and next-output decode; restart overrides any handshake
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sum_n   = sum;
        ptr_n   = ptr;
        we_n    = 1'b0;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        hold_n  = cpu_hold;
        done_n  = 1'b0;
        err_n   = err;

        if (restart) begin
            state_n = ST_LEN;
            sum_n   = '0;
            ptr_n   = '0;
            hold_n  = 1'b1;
            err_n   = 1'b0;
        end else begin
            unique case (state)
                ST_LEN: begin
                    if (hs) begin
                        cnt_n   = (s_data == DATA_W'(LEN_FULL)) ? CNT_W'(1 << ADDR_W)
                                                                 : CNT_W'(s_data);
                        sum_n   = '0;
                        ptr_n   = '0;
                        state_n = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        sum_n   = CHK_W'(sum + CHK_W'(s_data));
                        we_n    = 1'b1;
                        addr_n  = ptr;
                        wdata_n = s_data;
                        ptr_n   = ADDR_W'(ptr + ADDR_W'(1));
                        cnt_n   = CNT_W'(cnt - CNT_W'(1));
                        if (cnt == CNT_W'(1)) begin
                            state_n = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (hs) begin
                        if (CHK_W'(sum + CHK_W'(s_data)) == '0) begin
                            state_n = ST_RUN;
                            done_n  = 1'b1;
                            hold_n  = 1'b0;
                        end else begin
                            state_n = ST_ERR;
                            err_n   = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                end
                ST_ERR: begin
                end
                default: begin
                    state_n = ST_LEN;
                end
            endcase
        end

        ready_n = (state_n == ST_LEN) || (state_n == ST_DATA) || (state_n == ST_CHK);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a frame-position reference model.
module tb_imem_loader;

    logic       clk;
    logic       reset;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       restart;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    imem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .restart  (restart),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks byte position within the frame, not loader states
    int       m_pos;
    int       m_n;
    int       m_sum;
    logic     e_ready, e_hold, e_err, e_we, e_done;
    logic [7:0] e_addr, e_wdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos   <= 0;
            m_n     <= 0;
            m_sum   <= 0;
            e_ready <= 1'b1;
            e_hold  <= 1'b1;
            e_err   <= 1'b0;
            e_we    <= 1'b0;
            e_done  <= 1'b0;
            e_addr  <= 8'h00;
            e_wdata <= 8'h00;
        end else begin
            e_we   <= 1'b0;
            e_done <= 1'b0;
            if (restart) begin
                m_pos   <= 0;
                m_sum   <= 0;
                e_ready <= 1'b1;
                e_hold  <= 1'b1;
                e_err   <= 1'b0;
            end else if (s_valid && e_ready) begin
                if (m_pos == 0) begin
                    m_n   <= (s_data == 8'd0) ? 256 : int'(s_data);
                    m_sum <= 0;
                    m_pos <= 1;
                end else if (m_pos <= m_n) begin
                    e_we    <= 1'b1;
                    e_addr  <= 8'(m_pos - 1);
                    e_wdata <= s_data;
                    m_sum   <= (m_sum + int'(s_data)) % 256;
                    m_pos   <= m_pos + 1;
                end else begin
                    e_ready <= 1'b0;
                    m_pos   <= 0;
                    if ((m_sum + int'(s_data)) % 256 == 0) begin
                        e_done <= 1'b1;
                        e_hold <= 1'b0;
                    end else begin
                        e_err <= 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model plus a log of observed writes
    logic [15:0] wr_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        chk("s_ready", int'(s_ready), int'(e_ready));
        chk("cpu_hold", int'(cpu_hold), int'(e_hold));
        chk("err", int'(err), int'(e_err));
        chk("mem_we", int'(mem_we), int'(e_we));
        chk("done", int'(done), int'(e_done));
        if (e_we) begin
            chk("mem_addr", int'(mem_addr), int'(e_addr));
            chk("mem_wdata", int'(mem_wdata), int'(e_wdata));
        end
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
        if (done) done_cnt++;
    end

    logic [7:0] frame_q[$];

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        restart = r;
    endtask

    task automatic send_frame(input bit gap);
        foreach (frame_q[i]) begin
            drive(1'b1, frame_q[i], 1'b0);
            if (gap) drive(1'b0, 8'h00, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic good_frame(input logic [7:0] chk_byte);
        frame_q = '{8'h03, 8'h12, 8'h34, 8'h56, chk_byte};
    endtask

    task automatic check_three(input string name, input int base);
        chk({name, "_nwr"}, wr_q.size() - base, 3);
        if (wr_q.size() - base == 3) begin
            chk({name, "_w0"}, int'(wr_q[base]),     16'h0012);
            chk({name, "_w1"}, int'(wr_q[base + 1]), 16'h0134);
            chk({name, "_w2"}, int'(wr_q[base + 2]), 16'h0256);
        end
    endtask

    task automatic do_restart();
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    int base;
    int dbase;
    int sum_full;

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        restart = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", int'(s_ready), 1);
        chk("rst_hold", int'(cpu_hold), 1);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        @(negedge clk);
        reset = 1'b0;

        // Good load
        base = wr_q.size(); dbase = done_cnt;
        good_frame(8'h64);
        send_frame(1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        check_three("good", base);
        chk("good_done", done_cnt - dbase, 1);
        chk("good_hold", int'(cpu_hold), 0);
        chk("good_err", int'(err), 0);
        chk("good_ready", int'(s_ready), 0);

        // Bad checksum then restart
        do_restart();
        chk("rs_hold", int'(cpu_hold), 1);
        chk("rs_ready", int'(s_ready), 1);
        base = wr_q.size(); dbase = done_cnt;
        good_frame(8'h65);
        send_frame(1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        check_three("bad", base);
        chk("bad_err", int'(err), 1);
        chk("bad_hold", int'(cpu_hold), 1);
        chk("bad_ready", int'(s_ready), 0);
        chk("bad_done", done_cnt - dbase, 0);
        do_restart();
        chk("bad_rs_err", int'(err), 0);
        chk("bad_rs_ready", int'(s_ready), 1);

        // Full 256-byte frame; payload sum is 32640 = 0x80 mod 256, so CHK = 0x80
        base = wr_q.size(); dbase = done_cnt;
        frame_q = {};
        frame_q.push_back(8'h00);
        sum_full = 0;
        for (int i = 0; i < 256; i++) begin
            frame_q.push_back(8'(i));
            sum_full += i;
        end
        chk("full_model_sum", sum_full % 256, 8'h80);
        frame_q.push_back(8'h80);
        send_frame(1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        chk("full_nwr", wr_q.size() - base, 256);
        if (wr_q.size() - base >= 256) begin
            for (int i = 0; i < 256; i++) begin
                chk("full_wr", int'(wr_q[base + i]), (i << 8) | i);
            end
        end
        chk("full_done", done_cnt - dbase, 1);
        chk("full_hold", int'(cpu_hold), 0);

        // Gapped stream
        do_restart();
        base = wr_q.size(); dbase = done_cnt;
        good_frame(8'h64);
        send_frame(1'b1);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        check_three("gap", base);
        chk("gap_done", done_cnt - dbase, 1);

        // Reset mid-load after the second payload byte
        do_restart();
        base = wr_q.size();
        drive(1'b1, 8'h03, 1'b0);
        drive(1'b1, 8'h12, 1'b0);
        drive(1'b1, 8'h34, 1'b0);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h56;
        #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_nwr", wr_q.size() - base, 2);
        chk("mid_we", int'(mem_we), 0);
        chk("mid_addr", int'(mem_addr), 0);
        chk("mid_wdata", int'(mem_wdata), 0);
        chk("mid_hold", int'(cpu_hold), 1);
        chk("mid_ready", int'(s_ready), 1);
        chk("mid_err", int'(err), 0);
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        base = wr_q.size(); dbase = done_cnt;
        good_frame(8'h64);
        send_frame(1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        check_three("after_rst", base);
        chk("after_rst_done", done_cnt - dbase, 1);

        // Restart colliding with a handshaken payload byte
        do_restart();
        base = wr_q.size(); dbase = done_cnt;
        drive(1'b1, 8'h03, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'hAA, 1'b1);
        good_frame(8'h64);
        send_frame(1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        chk("col_nwr", wr_q.size() - base, 4);
        if (wr_q.size() - base == 4) begin
            chk("col_w0", int'(wr_q[base]), 16'h0011);
            check_three("col", base + 1);
        end
        chk("col_done", done_cnt - dbase, 1);
        chk("col_hold", int'(cpu_hold), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
